// File: rtl/multi_debounce_ctrl_pkg.sv
// Purpose: shared constants, event encoding and width helpers for the
//          multi-channel debounce controller and its round-robin arbiter.
// Contents: DEF_TICK_DIV / DEF_DB_TICKS defaults, evt_type_e (EVT_RISE /
//           EVT_FALL), clog2() and clog2w() (clog2 clamped to >= 1 bit).
package multi_debounce_ctrl_pkg;

    localparam int unsigned DEF_TICK_DIV = 50_000;
    localparam int unsigned DEF_DB_TICKS = 20;

    typedef enum logic {
        EVT_FALL = 1'b0,
        EVT_RISE = 1'b1
    } evt_type_e;

    // Smallest r with 2**r >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Width helper: never returns 0 so vectors stay legal for v <= 1.
    function automatic int unsigned clog2w(input int unsigned v);
        return (clog2(v) == 0) ? 1 : clog2(v);
    endfunction

endpackage

// File: rtl/multi_debounce_ctrl_rr_arbiter.sv
// Purpose: reusable round-robin arbiter. Searches the request vector starting
//          at a rotating pointer; the pointer moves past the winner whenever
//          the consumer advances with a grant present.
// Ports:   clk, rst_n     clock, async active-low reset
//          i_req[N]       request vector
//          i_adv          consumer takes the current grant this cycle
//          o_gnt_vld_c    some request is granted (combinational)
//          o_gnt_oh_c[N]  one-hot grant (combinational)
//          o_gnt_idx_c    grant index (combinational)
module multi_debounce_ctrl_rr_arbiter
    import multi_debounce_ctrl_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           i_req,
    input  logic                   i_adv,
    output logic                   o_gnt_vld_c,
    output logic [N-1:0]           o_gnt_oh_c,
    output logic [clog2w(N)-1:0]   o_gnt_idx_c
);

    localparam int unsigned IDX_W = clog2w(N);

    logic [IDX_W-1:0] r_ptr;
    logic [2*N-1:0]   w_dbl;
    logic [N-1:0]     w_rot;
    logic             w_found;
    logic [IDX_W-1:0] w_off;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_nxt;

    // Rotate requests so bit 0 is the pointer position.
    assign w_dbl = {i_req, i_req};
    assign w_rot = w_dbl[r_ptr +: N];

    // Lowest set bit of the rotated vector is the winner's offset.
    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = IDX_W'(k);
            end
        end
    end

    // Undo the rotation modulo N.
    assign w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_idx = (w_sum >= (IDX_W+1)'(N)) ? IDX_W'(w_sum - (IDX_W+1)'(N))
                                            : IDX_W'(w_sum);
    assign w_nxt = (w_idx == IDX_W'(N - 1)) ? '0 : w_idx + IDX_W'(1);

    assign o_gnt_vld_c = w_found;
    assign o_gnt_idx_c = w_idx;
    assign o_gnt_oh_c  = w_found ? (N'(1) << w_idx) : '0;

    // Pointer rests one past the last channel served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_adv && w_found) begin
            r_ptr <= w_nxt;
        end
    end

endmodule

// File: rtl/multi_debounce_ctrl.sv
// Purpose: shared-timebase debounce controller. Raw inputs are synchronised,
//          filtered against a common prescaler tick, and accepted level
//          changes are queued as one pending press/release per channel, then
//          serialised round-robin onto a single valid/ready event port.
// Ports:   clk, rst_n               clock, async active-low reset
//          i_btn_raw[NUM_CH]        raw asynchronous inputs
//          o_level[NUM_CH]          debounced levels
//          o_evt_valid / i_evt_ready  event handshake
//          o_evt_ch, o_evt_rise     event channel and type (1 = press)
//          o_overrun[NUM_CH]        sticky lost-edge flags
//          i_ovr_clr                synchronous clear of o_overrun
module multi_debounce_ctrl
    import multi_debounce_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned TICK_DIV = DEF_TICK_DIV,
    parameter int unsigned DB_TICKS = DEF_DB_TICKS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         i_btn_raw,
    output logic [NUM_CH-1:0]         o_level,
    output logic                      o_evt_valid,
    input  logic                      i_evt_ready,
    output logic [clog2w(NUM_CH)-1:0] o_evt_ch,
    output logic                      o_evt_rise,
    output logic [NUM_CH-1:0]         o_overrun,
    input  logic                      i_ovr_clr
);

    localparam int unsigned CH_W  = clog2w(NUM_CH);
    localparam int unsigned PRE_W = clog2w(TICK_DIV);
    localparam int unsigned CNT_W = clog2w(DB_TICKS);

    logic [NUM_CH-1:0] r_sync1;
    logic [NUM_CH-1:0] r_sync2;
    logic [PRE_W-1:0]  r_presc;
    logic              w_tick;
    logic              r_evt_valid;
    logic [CH_W-1:0]   r_evt_ch;
    logic              r_evt_rise;
    logic              w_load;
    logic [NUM_CH-1:0] w_level;
    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_ptype;
    logic [NUM_CH-1:0] w_ovr;
    logic [NUM_CH-1:0] w_gnt_oh;
    logic              w_gnt_vld;
    logic [CH_W-1:0]   w_gnt_idx;

    // Two-flop synchroniser per channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Shared prescaler: one-cycle tick every TICK_DIV clocks.
    assign w_tick = (r_presc == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRE_W'(1);
        end
    end

    // Output register may take a new event when empty or being accepted.
    assign w_load = !r_evt_valid || i_evt_ready;

    multi_debounce_ctrl_rr_arbiter #(
        .N (NUM_CH)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (w_pend),
        .i_adv       (w_load),
        .o_gnt_vld_c (w_gnt_vld),
        .o_gnt_oh_c  (w_gnt_oh),
        .o_gnt_idx_c (w_gnt_idx)
    );

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic             r_lvl;
        logic             r_pend;
        evt_type_e        r_ptype;
        logic             r_ovr;
        logic             w_dis;
        logic             w_post;
        logic             w_drain;

        assign w_dis   = r_sync2[g] ^ r_lvl;
        assign w_post  = w_dis && w_tick && (r_cnt == CNT_W'(DB_TICKS - 1));
        assign w_drain = w_load && w_gnt_oh[g];

        // Filter: any agreement with the current level restarts the count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
                r_lvl <= 1'b0;
            end else if (!w_dis) begin
                r_cnt <= '0;
            end else if (w_post) begin
                r_lvl <= r_sync2[g];
                r_cnt <= '0;
            end else if (w_tick) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        // Pending slot: a second undelivered edge cancels the first.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pend  <= 1'b0;
                r_ptype <= EVT_FALL;
            end else if (w_post) begin
                if (!r_pend || w_drain) begin
                    r_pend  <= 1'b1;
                    r_ptype <= evt_type_e'(r_sync2[g]);
                end else begin
                    r_pend  <= 1'b0;
                end
            end else if (w_drain) begin
                r_pend <= 1'b0;
            end
        end

        // Sticky overrun; a new loss beats a simultaneous clear.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_ovr <= 1'b0;
            end else if (w_post && r_pend && !w_drain) begin
                r_ovr <= 1'b1;
            end else if (i_ovr_clr) begin
                r_ovr <= 1'b0;
            end
        end

        assign w_level[g] = r_lvl;
        assign w_pend[g]  = r_pend;
        assign w_ptype[g] = (r_ptype == EVT_RISE);
        assign w_ovr[g]   = r_ovr;
    end

    // Event output register; holds steady while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_valid <= 1'b0;
            r_evt_ch    <= '0;
            r_evt_rise  <= 1'b0;
        end else if (w_load) begin
            r_evt_valid <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_evt_ch   <= w_gnt_idx;
                r_evt_rise <= |(w_ptype & w_gnt_oh);
            end
        end
    end

    assign o_level     = w_level;
    assign o_evt_valid = r_evt_valid;
    assign o_evt_ch    = r_evt_ch;
    assign o_evt_rise  = r_evt_rise;
    assign o_overrun   = w_ovr;

endmodule

// File: tb/tb_multi_debounce_ctrl.sv
// Bench for multi_debounce_ctrl with TICK_DIV=4, DB_TICKS=3, NUM_CH=4:
// directed scenarios followed by a randomized phase, all compared against
// a behavioural model of the controller's rules.
module tb_multi_debounce_ctrl;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int DB = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] raw;
    logic [N-1:0] o_level;
    logic         o_evt_valid;
    logic         rdy;
    logic [1:0]   o_evt_ch;
    logic         o_evt_rise;
    logic [N-1:0] o_overrun;
    logic         clr;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        int ch;
        bit rise;
        int cyc;
    } ev_t;
    ev_t evq[$];

    multi_debounce_ctrl #(
        .NUM_CH   (N),
        .TICK_DIV (TD),
        .DB_TICKS (DB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_btn_raw   (raw),
        .o_level     (o_level),
        .o_evt_valid (o_evt_valid),
        .i_evt_ready (rdy),
        .o_evt_ch    (o_evt_ch),
        .o_evt_rise  (o_evt_rise),
        .o_overrun   (o_overrun),
        .i_ovr_clr   (clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: per channel, count ticks spent disagreeing with the
    // accepted level; on the DB-th such tick accept and post an edge.
    bit [N-1:0] m_s1, m_s2, m_lvl, m_pend, m_ptype, m_ovr;
    int         m_run[N];
    int         m_cyc, m_ptr, m_ch, m_sel, m_c;
    bit         m_v, m_rise, m_tick, m_load, m_post, m_drain, m_set;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pend = '0; m_ptype = '0; m_ovr = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
            m_cyc = 0; m_ptr = 0; m_ch = 0; m_v = 0; m_rise = 0;
        end else begin
            m_tick = ((m_cyc % TD) == TD - 1);
            m_cyc++;
            m_load = !m_v || rdy;
            m_sel = -1;
            if (m_load) begin
                for (int k = 0; k < N; k++) begin
                    m_c = (m_ptr + k) % N;
                    if (m_sel < 0 && m_pend[m_c]) m_sel = m_c;
                end
                if (m_sel >= 0) begin
                    m_v = 1; m_ch = m_sel; m_rise = m_ptype[m_sel];
                    m_ptr = (m_sel + 1) % N;
                end else begin
                    m_v = 0;
                end
            end
            for (int i = 0; i < N; i++) begin
                m_post  = 0;
                m_drain = (m_sel == i);
                m_set   = 0;
                if (m_s2[i] == m_lvl[i]) m_run[i] = 0;
                else if (m_tick) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_post = 1; m_lvl[i] = m_s2[i]; m_run[i] = 0;
                    end
                end
                if (m_post) begin
                    if (!m_pend[i] || m_drain) begin
                        m_pend[i] = 1; m_ptype[i] = m_lvl[i];
                    end else begin
                        m_pend[i] = 0; m_set = 1;
                    end
                end else if (m_drain) m_pend[i] = 0;
                if (m_set) m_ovr[i] = 1;
                else if (clr) m_ovr[i] = 0;
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
    end

    // Per-cycle comparison against the model, plus a log of delivered events.
    always @(negedge clk) begin
        #1;
        chk("level", 32'(o_level), 32'(m_lvl));
        chk("valid", 32'(o_evt_valid), 32'(m_v));
        if (m_v) begin
            chk("evt_ch", 32'(o_evt_ch), 32'(m_ch));
            chk("evt_rise", 32'(o_evt_rise), 32'(m_rise));
        end
        chk("overrun", 32'(o_overrun), 32'(m_ovr));
        if (rst_n === 1'b1 && o_evt_valid === 1'b1 && rdy === 1'b1)
            evq.push_back('{ch: int'(o_evt_ch), rise: o_evt_rise, cyc: cyc});
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_lv(input logic [N-1:0] t, input int maxc, output int n);
        n = 0;
        while (o_level !== t && n < maxc) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic chk_ev(input string tag, input int idx, input int ch, input bit rise);
        if (evq.size() > idx) begin
            chk({tag, "_ch"}, 32'(evq[idx].ch), 32'(ch));
            chk({tag, "_rise"}, 32'(evq[idx].rise), 32'(rise));
        end else begin
            chk({tag, "_missing"}, 32'(evq.size()), 32'(idx + 1));
        end
    endtask

    task automatic chk_b2b(input string tag, input int idx);
        if (evq.size() > idx + 1)
            chk(tag, 32'(evq[idx+1].cyc - evq[idx].cyc), 32'd1);
        else
            chk({tag, "_missing"}, 32'(evq.size()), 32'(idx + 2));
    endtask

    int n;
    int hold[N];

    initial begin
        rst_n = 1'b0; raw = '0; rdy = 1'b1; clr = 1'b0;
        cycles(3);
        chk("rst_level", 32'(o_level), 32'd0);
        chk("rst_valid", 32'(o_evt_valid), 32'd0);
        chk("rst_ch", 32'(o_evt_ch), 32'd0);
        chk("rst_rise", 32'(o_evt_rise), 32'd0);
        chk("rst_ovr", 32'(o_overrun), 32'd0);
        rst_n = 1'b1;
        cycles(5);

        // Clean press on ch2.
        evq.delete();
        raw[2] = 1'b1;
        wait_lv(4'b0100, 20, n);
        chk("s1_latency_ok", 32'(n >= 10 && n <= 14), 32'd1);
        cycles(15);
        chk("s1_count", 32'(evq.size()), 32'd1);
        chk_ev("s1", 0, 2, 1'b1);

        // Ch0 bounces every 5 cycles: never accepted, then settles high.
        evq.delete();
        for (int i = 0; i < 12; i++) begin
            raw[0] = ~raw[0];
            cycles(5);
        end
        chk("s2_no_evt", 32'(evq.size()), 32'd0);
        chk("s2_level", 32'(o_level), 32'b0100);
        raw[0] = 1'b1;
        wait_lv(4'b0101, 20, n);
        chk("s2_latency_ok", 32'(n >= 10 && n <= 14), 32'd1);
        cycles(5);
        chk("s2_count", 32'(evq.size()), 32'd1);
        chk_ev("s2", 0, 0, 1'b1);

        // Ch1 and ch3 on the same tick, consumer stalled for 10 cycles.
        evq.delete();
        rdy = 1'b0;
        raw[1] = 1'b1; raw[3] = 1'b1;
        wait_lv(4'b1111, 20, n);
        chk("s3_latency_ok", 32'(n >= 10 && n <= 14), 32'd1);
        cycles(1);
        for (int i = 0; i < 10; i++) begin
            chk("s3_stall_valid", 32'(o_evt_valid), 32'd1);
            chk("s3_stall_ch", 32'(o_evt_ch), 32'd1);
            chk("s3_stall_rise", 32'(o_evt_rise), 32'd1);
            cycles(1);
        end
        rdy = 1'b1;
        cycles(5);
        chk("s3_count", 32'(evq.size()), 32'd2);
        chk_ev("s3_a", 0, 1, 1'b1);
        chk_ev("s3_b", 1, 3, 1'b1);
        chk_b2b("s3_b2b", 0);

        // Ch0 press+release both accepted behind a stalled ch2 event.
        raw[0] = 1'b0;
        wait_lv(4'b1110, 20, n);
        cycles(4);
        evq.delete();
        rdy = 1'b0;
        raw[2] = 1'b0;
        wait_lv(4'b1010, 20, n);
        cycles(2);
        chk("s4_block_valid", 32'(o_evt_valid), 32'd1);
        chk("s4_block_ch", 32'(o_evt_ch), 32'd2);
        raw[0] = 1'b1;
        wait_lv(4'b1011, 20, n);
        chk("s4_ovr_before", 32'(o_overrun), 32'd0);
        raw[0] = 1'b0;
        wait_lv(4'b1010, 20, n);
        cycles(1);
        chk("s4_ovr_set", 32'(o_overrun), 32'b0001);
        rdy = 1'b1;
        cycles(5);
        chk("s4_count", 32'(evq.size()), 32'd1);
        chk_ev("s4", 0, 2, 1'b0);
        chk("s4_ovr_sticky", 32'(o_overrun), 32'b0001);
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        chk("s4_ovr_clr", 32'(o_overrun), 32'd0);

        // Reset while an event is stalled; held inputs re-accepted afterwards.
        rdy = 1'b0;
        raw = 4'b1111;
        n = 0;
        while (o_evt_valid !== 1'b1 && n < 20) begin
            cycles(1);
            n++;
        end
        chk("s5_valid_before_rst", 32'(o_evt_valid), 32'd1);
        cycles(2);
        rst_n = 1'b0;
        #1;
        chk("s5_rst_level", 32'(o_level), 32'd0);
        chk("s5_rst_valid", 32'(o_evt_valid), 32'd0);
        chk("s5_rst_ch", 32'(o_evt_ch), 32'd0);
        chk("s5_rst_rise", 32'(o_evt_rise), 32'd0);
        chk("s5_rst_ovr", 32'(o_overrun), 32'd0);
        cycles(1);
        rst_n = 1'b1;
        rdy = 1'b1;
        evq.delete();
        wait_lv(4'b1111, 20, n);
        chk("s5_latency", 32'(n), 32'd12);
        cycles(6);
        chk("s5_count", 32'(evq.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk_ev("s5_press", i, i, 1'b1);
        for (int i = 0; i < 3; i++) chk_b2b("s5_press_b2b", i);
        raw = 4'b0000;
        wait_lv(4'b0000, 20, n);
        cycles(6);
        chk("s5_count2", 32'(evq.size()), 32'd8);
        for (int i = 0; i < 4; i++) chk_ev("s5_rel", i + 4, i, 1'b0);
        for (int i = 4; i < 7; i++) chk_b2b("s5_rel_b2b", i);

        // Randomized phase, checked cycle by cycle against the model.
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int t = 0; t < 2000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    raw[i]  = 1'($urandom_range(0, 1));
                    hold[i] = int'($urandom_range(1, 30));
                end else begin
                    hold[i]--;
                end
            end
            rdy = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 39) == 0);
            cycles(1);
        end
        clr = 1'b0;
        rdy = 1'b1;
        cycles(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
